arb_rr_var: RTL
===============

# arb_rr_var

Parameterized round-robin arbiter that shares one downstream resource among REQ_NUM requesters. It holds a grant until the owner signals completion, drops its request or exceeds a hold limit. It then inserts one turnaround cycle and re-arbitrates starting after the last owner. The registered owner index drives a decode_var instance to produce the one-hot grant vector, so grant encoding matches the team's existing decoder.

## Interface
- REQ_BITS, 2: owner index width.
- REQ_NUM, 4: number of requesters; must equal 2^REQ_BITS.
- HOLD_BITS, 8: hold counter width.
- MAX_HOLD, 16: maximum cycles a grant may be held; 0 disables the timeout; must be < 2^HOLD_BITS.
- clk  input  1  clock; all state is updated on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_in  input  REQ_NUM  request per requester; level-sensitive.
- done_in  input  1  owner's access complete; sampled only in BUSY.
- grant_out  output  REQ_NUM  one-hot grant; all zeros when grant_vld=0.
- grant_idx  output  REQ_BITS  binary index of the current owner; holds its last value when idle.
- grant_vld  output  1  a grant is active.
- timeout_out  output  1  one-cycle pulse when a grant is forcibly released.

## Operation
- FSM states: IDLE, BUSY, TURN.
- **IDLE:**
  - If any req_in bit is set, select the first set bit scanning from last_idx+1 upward, with index arithmetic modulo REQ_NUM (wraps from REQ_NUM-1 to 0).
  - Load grant_idx and last_idx with the selected index, clear hold_cnt, and go to BUSY.
  - With no request, stay in IDLE.
- **BUSY:**
  - grant_vld=1 and grant_out=decode(grant_idx).
  - hold_cnt increments each cycle and saturates at 2^HOLD_BITS-1.
  - Release condition: done_in=1, req_in[grant_idx]=0, or (MAX_HOLD≠0 and hold_cnt==MAX_HOLD-1). On release, go to TURN.
  - timeout_out=1 only when the timeout condition is the sole release cause. If done_in or a request drop coincides with the timeout, it is a normal release and timeout_out stays 0.
- **TURN:**
  - grant_vld=0, then return to IDLE unconditionally.
  - Requests are not sampled in TURN.
- Fairness:
  - last_idx updates only on a new grant.
  - A requester that just released has lowest priority in the next arbitration.
- Requests other than the owner's have no effect during BUSY or TURN.
- **Reset values:**
  - state=IDLE, grant_vld=0, grant_out=0, grant_idx=0, timeout_out=0, hold_cnt=0.
  - last_idx=REQ_NUM-1, so the first scan starts at index 0.
- Reset asserted mid-grant clears grant_vld and grant_out immediately (asynchronous), without waiting for a clock edge.

## Timing
- Arbitration latency: request sampled in IDLE at edge N gives grant_vld=1 after edge N.
- Grant outputs are registered; grant_out is combinational from the registered grant_idx and grant_vld through decode_var only.
- Normal release: release condition sampled at edge M gives grant_vld=0 after edge M.
- Turnaround: TURN lasts exactly one cycle, so the earliest re-grant is visible after edge M+2.
- With MAX_HOLD=K, grant_vld is high for exactly K cycles when uninterrupted, and timeout_out pulses in the first cycle of TURN.
- Minimum grant length is one cycle: done_in asserted in the first BUSY cycle is honoured.
- Back-to-back service of continuously requesting masters has a 3-cycle period per grant when done_in is asserted in the first BUSY cycle.

## Structure
- Shared package/include file:
  - FSM state encodings ST_IDLE=2'd0, ST_BUSY=2'd1, ST_TURN=2'd2.
  - Default REQ_BITS, HOLD_BITS and MAX_HOLD values.
- One sub-module: decode_var, instantiated with DATA_BITS=REQ_BITS and DCD_BITS=REQ_NUM. Its output is ANDed with grant_vld to form grant_out.
- The round-robin scan is a function or generate loop inside arb_rr_var; no further sub-modules.

## Test plan
- **Reset:** assert rst mid-BUSY with req_in=4'b0001. Required: grant_out=0 and grant_vld=0 immediately; after release, first grant goes to index 0.
- **Round-robin:**
  - Stimulus: req_in=4'b1111 held, done_in pulsed in each BUSY cycle.
  - Required: grant_idx sequence 0,1,2,3,0, with a 3-cycle period and grant_out=0001,0010,0100,1000.
- **Wrap and skip:** last owner 3, req_in=4'b0101. Required: grant to 0, then 2, then 0.
- **Timeout:**
  - Stimulus: MAX_HOLD=16, req_in[1] held, done_in=0.
  - Required: grant_vld high for exactly 16 cycles, one timeout_out pulse, next grant to another requester if one is pending.
- **Simultaneous events:**
  - done_in asserted on the timeout cycle gives release with timeout_out=0.
  - Owner drops its request in its first BUSY cycle gives release after one cycle.
- **Idle behaviour:** req_in=0 for 10 cycles. Required: stays IDLE, grant_vld=0, grant_idx unchanged.

Source files
------------

// File: rtl/arb_rr_var_pkg.sv
// Shared definitions for the round-robin arbiter: FSM state encodings and
// default parameter values used by arb_rr_var and its instantiations.
package arb_rr_var_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_TURN = 2'd2
    } arb_state_e;

    // Default configuration: four requesters, 8-bit hold counter, 16-cycle limit.
    localparam int DEF_REQ_BITS  = 2;
    localparam int DEF_HOLD_BITS = 8;
    localparam int DEF_MAX_HOLD  = 16;

endpackage : arb_rr_var_pkg

// File: rtl/arb_rr_var_decode.sv
// Binary-to-one-hot decoder. Output bit i is set when the input equals i.
// DCD_BITS is normally 2^DATA_BITS.
module decode_var #(
    parameter int DATA_BITS = 2,
    parameter int DCD_BITS  = 4
) (
    input  logic [DATA_BITS-1:0] data_i,
    output logic [DCD_BITS-1:0]  dcd_o
);

    // One-hot decode of the binary input.
    always_comb begin
        dcd_o = '0;
        for (int i = 0; i < DCD_BITS; i++) begin
            dcd_o[i] = (data_i == DATA_BITS'(i));
        end
    end

endmodule : decode_var

// File: rtl/arb_rr_var.sv
// Round-robin arbiter for REQ_NUM requesters sharing one resource. A grant
// is held until done, request drop or hold limit, followed by one turnaround
// cycle; the next scan starts just after the previous owner.
module arb_rr_var
    import arb_rr_var_pkg::*;
#(
    parameter int REQ_BITS  = DEF_REQ_BITS,
    parameter int REQ_NUM   = 4,
    parameter int HOLD_BITS = DEF_HOLD_BITS,
    parameter int MAX_HOLD  = DEF_MAX_HOLD
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [REQ_NUM-1:0]  req_in,
    input  logic                done_in,
    output logic [REQ_NUM-1:0]  grant_out,
    output logic [REQ_BITS-1:0] grant_idx,
    output logic                grant_vld,
    output logic                timeout_out
);

    // Hold counter value at which the grant is forcibly released
    // (only meaningful when MAX_HOLD is non-zero).
    localparam int                   HOLD_LAST_INT = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
    localparam logic [HOLD_BITS-1:0] HOLD_LAST     = HOLD_BITS'(HOLD_LAST_INT);
    localparam logic [HOLD_BITS-1:0] HOLD_SAT      = '1;

    arb_state_e          state_q, state_d;
    logic [REQ_BITS-1:0] grant_idx_q, grant_idx_d;
    logic [REQ_BITS-1:0] last_idx_q, last_idx_d;
    logic [HOLD_BITS-1:0] hold_cnt_q, hold_cnt_d;
    logic                timeout_q, timeout_d;

    logic [REQ_NUM-1:0]  dcd_vec;
    logic                tmo_hit;
    logic                owner_drop;
    logic                rel_busy;

    // First set request scanning upward from last+1, modulo REQ_NUM. The loop
    // walks the offsets from farthest to nearest so the nearest hit wins; the
    // offset REQ_NUM lands back on the last owner, giving it lowest priority.
    function automatic logic [REQ_BITS-1:0] rr_pick(
        input logic [REQ_NUM-1:0]  req,
        input logic [REQ_BITS-1:0] last
    );
        logic [REQ_BITS-1:0] idx;
        logic [REQ_BITS-1:0] pick;
        pick = last;
        for (int k = REQ_NUM; k >= 1; k--) begin
            idx = last + REQ_BITS'(k);
            if (req[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

    // Saturating increment of the hold counter.
    function automatic logic [HOLD_BITS-1:0] hold_inc(input logic [HOLD_BITS-1:0] cnt);
        return (cnt == HOLD_SAT) ? cnt : cnt + 1'b1;
    endfunction

    assign tmo_hit    = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);
    assign owner_drop = !req_in[grant_idx_q];
    assign rel_busy   = done_in || owner_drop || tmo_hit;

    // Next-state, grant and hold-counter logic for the IDLE/BUSY/TURN FSM.
    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        last_idx_d  = last_idx_q;
        hold_cnt_d  = hold_cnt_q;
        timeout_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|req_in) begin
                    grant_idx_d = rr_pick(req_in, last_idx_q);
                    last_idx_d  = grant_idx_d;
                    hold_cnt_d  = '0;
                    state_d     = ST_BUSY;
                end
            end
            ST_BUSY: begin
                hold_cnt_d = hold_inc(hold_cnt_q);
                if (rel_busy) begin
                    state_d = ST_TURN;
                    // Forced release is flagged only when nothing else ended the grant.
                    timeout_d = tmo_hit && !done_in && !owner_drop;
                end
            end
            ST_TURN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and grant registers; reset clears the grant immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            grant_idx_q <= '0;
            last_idx_q  <= REQ_BITS'(REQ_NUM - 1);
            hold_cnt_q  <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            last_idx_q  <= last_idx_d;
            hold_cnt_q  <= hold_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    decode_var #(
        .DATA_BITS (REQ_BITS),
        .DCD_BITS  (REQ_NUM)
    ) u_decode (
        .data_i (grant_idx_q),
        .dcd_o  (dcd_vec)
    );

    assign grant_vld   = (state_q == ST_BUSY);
    assign grant_idx   = grant_idx_q;
    assign grant_out   = dcd_vec & {REQ_NUM{grant_vld}};
    assign timeout_out = timeout_q;

endmodule : arb_rr_var
